// File: rtl/bg_pkg.sv
// Shared definitions for the background-memory arbiter: default widths,
// clear-fill end address and FSM state encoding.
package bg_pkg;

    localparam int          DEF_ADDR_W   = 20;
    localparam int          DEF_DATA_W   = 12;
    localparam logic [19:0] DEF_CLR_LAST = 20'hBFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        CLR  = 2'd2
    } bg_state_t;

endpackage

// File: rtl/bg_wr_fifo.sv
// Synchronous FIFO holding {addr,data} write requests; exposes full/empty
// and a "last" flag (exactly one entry left) so the consumer can exit on the final pop.
module bg_wr_fifo #(
    parameter int AW    = 20,
    parameter int DW    = 12,
    parameter int DEPTH = 8
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty,
    output logic          last
);

    localparam int PW = $clog2(DEPTH);

    logic [AW+DW-1:0] store [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (count == (PW+1)'(DEPTH));
    assign last    = (count == (PW+1)'(1));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign {head_addr, head_data} = store[rptr[PW-1:0]];

    always_ff @(posedge pclk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (PW+1)'(1);
            if (do_pop)  rptr <= rptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (do_push) store[wptr[PW-1:0]] <= {push_addr, push_data};
    end

endmodule

// File: rtl/bg_mem_arbiter.sv
// Background frame-memory port arbiter: display reads always win, buffered writes
// and the clear-to-colour fill use free cycles. Optional stall/full counters: BG_ARB_STATS_EN.
module bg_mem_arbiter
    import bg_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(DEF_CLR_LAST)
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rgb,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef BG_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       full_cnt,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    bg_state_t         state, state_nx;
    logic              clr_pend, clr_pend_nx;
    logic              clr_busy_nx;
    logic [DATA_W-1:0] clr_color_q, clr_color_nx;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
    logic              rdy_en;
    logic              push, pop, clr_accept;
    logic              fifo_full, fifo_empty, fifo_last;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign disp_rgb   = mem_rdata;
    assign wr_ready   = rdy_en & ~fifo_full & ~clr_busy;
    assign push       = wr_valid & wr_ready;
    assign clr_accept = clr_start & ~clr_busy;

    bg_wr_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pclk      (pclk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .last      (fifo_last)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= IDLE;
            clr_pend    <= 1'b0;
            clr_busy    <= 1'b0;
            clr_color_q <= '0;
            clr_cnt     <= '0;
            rdy_en      <= 1'b0;
        end else begin
            state       <= state_nx;
            clr_pend    <= clr_pend_nx;
            clr_busy    <= clr_busy_nx;
            clr_color_q <= clr_color_nx;
            clr_cnt     <= clr_cnt_nx;
            rdy_en      <= 1'b1;
        end
    end

    // A clear requested while writes are queued (or being pushed) waits as pending,
    // so every earlier write reaches memory before the fill begins.
    always_comb begin
        state_nx     = state;
        clr_pend_nx  = clr_pend;
        clr_busy_nx  = clr_busy;
        clr_color_nx = clr_color_q;
        clr_cnt_nx   = clr_cnt;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        pop          = 1'b0;

        if (disp_req) mem_addr = disp_addr;

        if (clr_accept && state != CLR) begin
            clr_color_nx = clr_color;
            clr_cnt_nx   = '0;
            clr_busy_nx  = 1'b1;
        end

        case (state)
            IDLE: begin
                if (clr_accept) begin
                    if (!fifo_empty || push) begin
                        clr_pend_nx = 1'b1;
                        state_nx    = WR;
                    end else begin
                        state_nx    = CLR;
                    end
                end else if (!fifo_empty) begin
                    state_nx = WR;
                end
            end
            WR: begin
                if (clr_accept) clr_pend_nx = 1'b1;
                if (!disp_req && !fifo_empty) begin
                    mem_we    = 1'b1;
                    mem_addr  = head_addr;
                    mem_wdata = head_data;
                    pop       = 1'b1;
                    if (fifo_last && !push) begin
                        if (clr_pend || clr_accept) begin
                            clr_pend_nx = 1'b0;
                            state_nx    = CLR;
                        end else begin
                            state_nx    = IDLE;
                        end
                    end
                end
            end
            CLR: begin
                if (!disp_req) begin
                    mem_we     = 1'b1;
                    mem_addr   = clr_cnt;
                    mem_wdata  = clr_color_q;
                    clr_cnt_nx = clr_cnt + ADDR_W'(1);
                    if (clr_cnt == CLR_LAST) begin
                        state_nx    = IDLE;
                        clr_busy_nx = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef BG_ARB_STATS_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge pclk) begin
        if (rst || stats_clr) begin
            stall_cnt <= '0;
            full_cnt  <= '0;
        end else begin
            if (!fifo_empty && disp_req && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (wr_valid && !wr_ready && full_cnt != 16'hFFFF)
                full_cnt <= full_cnt + 16'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_bg_mem_arbiter.sv
// Self-checking bench for bg_mem_arbiter: directed tables and sequences plus
// randomized traffic checked against a queue-based model of expected memory writes.
module tb_bg_mem_arbiter;

    localparam logic [19:0] CLR_LAST_TB = 20'h003FF;
    localparam int          DEPTH       = 8;

    logic        pclk, rst;
    logic        disp_req, wr_valid, wr_ready, clr_start, clr_busy, mem_we;
    logic [19:0] disp_addr, wr_addr, mem_addr;
    logic [11:0] disp_rgb, wr_data, clr_color, mem_wdata, mem_rdata;
`ifdef BG_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] stall_cnt, full_cnt;
`endif

    bg_mem_arbiter #(
        .ADDR_W     (20),
        .DATA_W     (12),
        .FIFO_DEPTH (DEPTH),
        .CLR_LAST   (CLR_LAST_TB)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_rgb  (disp_rgb),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
`ifdef BG_ARB_STATS_EN
        .stats_clr (stats_clr),
        .stall_cnt (stall_cnt),
        .full_cnt  (full_cnt),
`endif
        .mem_rdata (mem_rdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Memory device: unwritten locations read back as addr[11:0].
    logic [11:0] dev_mem [0:(1<<20)-1];
    bit          dev_wr  [0:(1<<20)-1];
    always @(posedge pclk) begin
        if (mem_we) begin
            dev_mem[mem_addr] <= mem_wdata;
            dev_wr[mem_addr]  <= 1'b1;
        end
        mem_rdata <= dev_wr[mem_addr] ? dev_mem[mem_addr] : mem_addr[11:0];
    end

    typedef struct {
        logic [19:0] addr;
        logic [11:0] data;
        bit          from_fifo;
        bit          is_last;
    } wr_t;

    typedef struct {
        logic        disp_req;
        logic [19:0] disp_addr;
        logic        wr_valid;
        logic [19:0] wr_addr;
        logic [11:0] wr_data;
        logic        exp_we;
        logic [19:0] exp_addr;
        logic [11:0] exp_wdata;
        logic        exp_ready;
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;
    wr_t         exp_q[$];
    int          occ = 0;
    bit          busy_m = 0;
    bit          rdy_m = 0;
    logic        disp_prev = 1'b0;
    logic [11:0] disp_exp = '0;
    bit          last_we = 0;
    logic [19:0] last_addr = '0;
    logic [11:0] ref_mem [0:(1<<20)-1];
    bit          ref_wr  [0:(1<<20)-1];
    vec_t        tbl [6];

    function automatic logic [11:0] ref_rd(input logic [19:0] a);
        return ref_wr[a] ? ref_mem[a] : a[11:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic dr, input logic [19:0] da, input logic wv,
                                 input logic [19:0] wa, input logic [11:0] wd,
                                 input logic cs, input logic [11:0] cc);
        disp_req  = dr;
        disp_addr = da;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        clr_start = cs;
        clr_color = cc;
    endtask

    // One clock: check the port against the model, record accepted requests, advance.
    task automatic runCycle();
        bit  exp_ready, rst_s, set_busy, drop_busy;
        wr_t w;
        #2;
        set_busy  = 0;
        drop_busy = 0;
        exp_ready = rdy_m && (occ < DEPTH) && !busy_m;
        checkOutput("wr_ready", 32'(wr_ready), 32'(exp_ready));
        checkOutput("clr_busy", 32'(clr_busy), 32'(busy_m));
        if (disp_prev) checkOutput("disp_rgb", 32'(disp_rgb), 32'(disp_exp));
        if (disp_req) begin
            checkOutput("disp_we", 32'(mem_we), 32'(0));
            checkOutput("disp_addr", 32'(mem_addr), 32'(disp_addr));
        end else if (mem_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL spurious_write: got write at %0h, expected no write", mem_addr);
            end else begin
                w = exp_q.pop_front();
                checkOutput("mem_addr", 32'(mem_addr), 32'(w.addr));
                checkOutput("mem_wdata", 32'(mem_wdata), 32'(w.data));
                ref_mem[w.addr] = w.data;
                ref_wr[w.addr]  = 1'b1;
                if (w.from_fifo) occ--;
                if (w.is_last) drop_busy = 1;
            end
        end
        if (wr_valid && exp_ready) begin
            exp_q.push_back('{wr_addr, wr_data, 1'b1, 1'b0});
            occ++;
        end
        if (clr_start && !busy_m && !rst) begin
            for (int a = 0; a <= int'(CLR_LAST_TB); a++)
                exp_q.push_back('{20'(a), clr_color, 1'b0, (a == int'(CLR_LAST_TB))});
            set_busy = 1;
        end
        disp_prev = disp_req;
        disp_exp  = ref_rd(disp_addr);
        last_we   = mem_we && !disp_req;
        last_addr = mem_addr;
        rst_s     = rst;
        @(posedge pclk);
        #1;
        if (rst_s) begin
            exp_q.delete();
            occ    = 0;
            busy_m = 0;
            rdy_m  = 0;
        end else begin
            rdy_m = 1;
            if (set_busy)  busy_m = 1;
            if (drop_busy) busy_m = 0;
        end
    endtask

    task automatic drain(input int limit, input bit toggle);
        for (int i = 0; i < limit && (exp_q.size() != 0 || busy_m); i++) begin
            applyStimulus(toggle && (i % 2 == 0), 20'($urandom_range(0, 4095)), 1'b0, '0, '0, 1'b0, '0);
            runCycle();
        end
        checkOutput("drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
`ifdef BG_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        tbl[0] = '{1'b1, 20'h00010, 1'b1, 20'h00005, 12'hF00, 1'b0, 20'h00010, 12'h000, 1'b1};
        tbl[1] = '{1'b1, 20'h00011, 1'b1, 20'h00406, 12'h0F0, 1'b0, 20'h00011, 12'h000, 1'b1};
        tbl[2] = '{1'b1, 20'h00012, 1'b0, 20'h00000, 12'h000, 1'b0, 20'h00012, 12'h000, 1'b1};
        tbl[3] = '{1'b0, 20'h00000, 1'b0, 20'h00000, 12'h000, 1'b1, 20'h00005, 12'hF00, 1'b1};
        tbl[4] = '{1'b0, 20'h00000, 1'b0, 20'h00000, 12'h000, 1'b1, 20'h00406, 12'h0F0, 1'b1};
        tbl[5] = '{1'b0, 20'h00000, 1'b0, 20'h00000, 12'h000, 1'b0, 20'h00000, 12'h000, 1'b1};

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        @(posedge pclk);
        #1;
        #2;
        checkOutput("rst_mem_we", 32'(mem_we), 32'(0));
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'(0));
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        runCycle();
        rst = 1'b0;
        runCycle();

        $display("[TB] display-only reads");
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b1, 20'(a), 1'b0, '0, '0, 1'b0, '0);
            runCycle();
        end

        $display("[TB] writes queued behind display, released in blanking");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].disp_req, tbl[i].disp_addr, tbl[i].wr_valid,
                          tbl[i].wr_addr, tbl[i].wr_data, 1'b0, '0);
            #2;
            checkOutput("tbl_we", 32'(mem_we), 32'(tbl[i].exp_we));
            checkOutput("tbl_addr", 32'(mem_addr), 32'(tbl[i].exp_addr));
            checkOutput("tbl_wdata", 32'(mem_wdata), 32'(tbl[i].exp_wdata));
            checkOutput("tbl_ready", 32'(wr_ready), 32'(tbl[i].exp_ready));
            runCycle();
        end

        $display("[TB] FIFO full while display holds the port");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 20'(i), 1'b1, 20'h00100 + 20'(i), 12'h100 + 12'(i), 1'b0, '0);
            #2;
            checkOutput("fill_ready", 32'(wr_ready), 32'(1));
            runCycle();
        end
        applyStimulus(1'b1, 20'h00020, 1'b0, '0, '0, 1'b0, '0);
        #2;
        checkOutput("full_ready", 32'(wr_ready), 32'(0));
        runCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        #2;
        checkOutput("free_we", 32'(mem_we), 32'(1));
        runCycle();
        applyStimulus(1'b1, 20'h00021, 1'b0, '0, '0, 1'b0, '0);
        #2;
        checkOutput("ready_after_pop", 32'(wr_ready), 32'(1));
        runCycle();
        drain(40, 1'b0);

        $display("[TB] clear fill with display on alternate cycles");
        applyStimulus(1'b1, 20'h00030, 1'b0, '0, '0, 1'b1, 12'h08F);
        runCycle();
        drain(5000, 1'b1);

        $display("[TB] clear requested behind queued writes");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 20'(i), 1'b1, 20'h00200 + 20'(i), 12'hA00 + 12'(i), 1'b0, '0);
            runCycle();
        end
        applyStimulus(1'b1, 20'h00040, 1'b0, '0, '0, 1'b1, 12'h5A5);
        runCycle();
        drain(5000, 1'b1);

        $display("[TB] reset in the middle of a clear");
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 12'hC3C);
        runCycle();
        for (int i = 0; i < 2000 && !(last_we && last_addr == 20'h000FF); i++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
            runCycle();
        end
        checkOutput("reach_0ff", 32'(last_addr), 32'(20'h000FF));
        rst = 1'b1;
        runCycle();
        #2;
        checkOutput("rst_clr_busy", 32'(clr_busy), 32'(0));
        checkOutput("rst_clr_we", 32'(mem_we), 32'(0));
        checkOutput("rst_clr_ready", 32'(wr_ready), 32'(0));
        runCycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) runCycle();
        #2;
        checkOutput("post_rst_ready", 32'(wr_ready), 32'(1));
        checkOutput("post_rst_we", 32'(mem_we), 32'(0));
        runCycle();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, 20'($urandom_range(0, 4095)),
                          1'($urandom_range(0, 1)), 20'($urandom_range(0, 4095)),
                          12'($urandom), (i == 300), 12'($urandom));
            runCycle();
        end
        drain(6000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
